// File: rtl/icache_lines_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and field-width helpers.
package icache_lines_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   localparam int unsigned WordBytesLog2 = 2;

   function automatic int unsigned tag_bits(input int unsigned addr_width,
                                            input int unsigned index_bits,
                                            input int unsigned line_words_log2);
      return addr_width - index_bits - line_words_log2 - WordBytesLog2;
   endfunction

endpackage

// File: rtl/icache_lines_if.sv
// Fetch-side and memory-adaptor-side signals of the instruction cache.
interface icache_lines_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] read_addr;
   logic                  is_reading;
   logic [31:0]           read_data;
   logic                  is_ready;
   logic [31:0]           ins_fetched_from_memory_adaptor;
   logic                  insfetch_task_done;
   logic                  request_ins_from_memory_adaptor;
   logic [ADDR_WIDTH-1:0] insaddr_to_be_fetched_from_memory_adaptor;

   modport slave (
      input  read_addr, is_reading, ins_fetched_from_memory_adaptor, insfetch_task_done,
      output read_data, is_ready, request_ins_from_memory_adaptor,
             insaddr_to_be_fetched_from_memory_adaptor
   );

   modport master (
      output read_addr, is_reading, ins_fetched_from_memory_adaptor, insfetch_task_done,
      input  read_data, is_ready, request_ins_from_memory_adaptor,
             insaddr_to_be_fetched_from_memory_adaptor
   );
endinterface

// File: rtl/icache_line_store.sv
// Data/tag arrays and per-line valid bits; one combinational read port, one word-write port.
module icache_line_store #(
   parameter int unsigned INDEX_BITS      = 6,
   parameter int unsigned LINE_WORDS_LOG2 = 2,
   parameter int unsigned TAG_BITS        = 22
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       en,
   input  logic                       clear_all,
   input  logic [INDEX_BITS-1:0]      rd_index,
   input  logic [LINE_WORDS_LOG2-1:0] rd_offset,
   output logic [31:0]                rd_word,
   output logic [TAG_BITS-1:0]        rd_tag,
   output logic                       rd_valid,
   input  logic                       wr_en,
   input  logic [INDEX_BITS-1:0]      wr_index,
   input  logic [LINE_WORDS_LOG2-1:0] wr_offset,
   input  logic [31:0]                wr_word,
   input  logic                       tag_we,
   input  logic [TAG_BITS-1:0]        wr_tag
);
   localparam int unsigned Lines = 1 << INDEX_BITS;
   localparam int unsigned Words = 1 << LINE_WORDS_LOG2;

   logic [31:0]          data_q [Lines*Words];
   logic [TAG_BITS-1:0]  tag_q  [Lines];
   logic [Lines-1:0]     valid_q;

   assign rd_word  = data_q[{rd_index, rd_offset}];
   assign rd_tag   = tag_q[rd_index];
   assign rd_valid = valid_q[rd_index];

   always_ff @(posedge clk_in) begin
      if (en && wr_en)  data_q[{wr_index, wr_offset}] <= wr_word;
      if (en && tag_we) tag_q[wr_index] <= wr_tag;
   end

   // Clear wins over a coincident line fill so the refilled line ends invalid.
   always_ff @(posedge clk_in) begin
      if (rst_in)              valid_q <= '0;
      else if (en) begin
         if (clear_all)        valid_q <= '0;
         else if (tag_we)      valid_q[wr_index] <= 1'b1;
      end
   end

endmodule

// File: rtl/icache_lines.sv
// Direct-mapped instruction cache with word-at-a-time line refill.
// Optional ICACHE_PERF_COUNTERS_EN adds hit_count/miss_count outputs.
module icache_lines
   import icache_lines_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned INDEX_BITS      = 6,
   parameter int unsigned LINE_WORDS_LOG2 = 2
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          flush_pipline,
   input  logic          invalidate_all,
   icache_lines_if.slave bus
`ifdef ICACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
`endif
);
   localparam int unsigned OffBits = LINE_WORDS_LOG2;
   localparam int unsigned IdxLsb  = LINE_WORDS_LOG2 + WordBytesLog2;
   localparam int unsigned TagLsb  = IdxLsb + INDEX_BITS;
   localparam int unsigned TagBits = tag_bits(ADDR_WIDTH, INDEX_BITS, LINE_WORDS_LOG2);

   if (INDEX_BITS + LINE_WORDS_LOG2 + 2 >= ADDR_WIDTH) begin : g_bad_cfg
      $error("icache_lines: INDEX_BITS + LINE_WORDS_LOG2 + 2 must be below ADDR_WIDTH");
   end

   state_e                       state_q, state_d;
   logic [ADDR_WIDTH-1:IdxLsb]   line_q, line_d;
   logic [OffBits-1:0]           off_q, off_d, cnt_q, cnt_d, cnt_inc;
   logic [31:0]                  cap_q, cap_d, rdata_q, rdata_d;
   logic                         ready_q, ready_d;
   logic [ADDR_WIDTH-1:0]        req_addr_q, req_addr_d;

   logic [31:0]          rd_word;
   logic [TagBits-1:0]   rd_tag;
   logic                 rd_valid, hit, wr_en, tag_we, lookup_hit, lookup_miss;
   logic [31:0]          mem_word;

   assign mem_word = bus.ins_fetched_from_memory_adaptor;
   assign hit      = rd_valid && (rd_tag == bus.read_addr[ADDR_WIDTH-1:TagLsb]);
   assign cnt_inc  = cnt_q + 1'b1;

   icache_line_store #(
      .INDEX_BITS      (INDEX_BITS),
      .LINE_WORDS_LOG2 (LINE_WORDS_LOG2),
      .TAG_BITS        (TagBits)
   ) u_store (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .clear_all (invalidate_all),
      .rd_index  (bus.read_addr[TagLsb-1:IdxLsb]),
      .rd_offset (bus.read_addr[IdxLsb-1:WordBytesLog2]),
      .rd_word   (rd_word),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .wr_en     (wr_en),
      .wr_index  (line_q[TagLsb-1:IdxLsb]),
      .wr_offset (cnt_q),
      .wr_word   (mem_word),
      .tag_we    (tag_we),
      .wr_tag    (line_q[ADDR_WIDTH-1:TagLsb])
   );

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      cap_d       = cap_q;
      rdata_d     = rdata_q;
      ready_d     = ready_q;
      req_addr_d  = req_addr_q;
      wr_en       = 1'b0;
      tag_we      = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      if (flush_pipline) begin
         // The adaptor drops its task too, so any partial line simply stays invalid.
         state_d = StIdle;
         ready_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.is_reading) begin
                  if (hit) begin
                     lookup_hit = 1'b1;
                     rdata_d    = rd_word;
                  end else begin
                     lookup_miss = 1'b1;
                     line_d      = bus.read_addr[ADDR_WIDTH-1:IdxLsb];
                     off_d       = bus.read_addr[IdxLsb-1:WordBytesLog2];
                     cnt_d       = '0;
                     ready_d     = 1'b0;
                     req_addr_d  = {bus.read_addr[ADDR_WIDTH-1:IdxLsb], {OffBits{1'b0}}, 2'b00};
                     state_d     = StReq;
                  end
               end
            end
            StReq: state_d = StWait;
            StWait: begin
               if (bus.insfetch_task_done) begin
                  wr_en = 1'b1;
                  if (cnt_q == off_q) cap_d = mem_word;
                  if (&cnt_q) begin
                     tag_we  = 1'b1;
                     rdata_d = (cnt_q == off_q) ? mem_word : cap_q;
                     ready_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     cnt_d      = cnt_inc;
                     req_addr_d = {line_q, cnt_inc, 2'b00};
                     state_d    = StReq;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         line_q     <= '0;
         off_q      <= '0;
         cnt_q      <= '0;
         cap_q      <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b1;
         req_addr_q <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         line_q     <= line_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign bus.read_data                                 = rdata_q;
   assign bus.is_ready                                  = ready_q;
   assign bus.request_ins_from_memory_adaptor           = (state_q == StReq);
   assign bus.insaddr_to_be_fetched_from_memory_adaptor = req_addr_q;

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (rdy_in) begin
         if (lookup_hit)  hit_q  <= hit_q + 32'd1;
         if (lookup_miss) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_lines.sv
// Directed bench for icache_lines: fills, hits, conflicts, flush, invalidate and rdy_in pause.
module tb_icache_lines;
   logic clk_in = 1'b0;
   logic rst_in, rdy_in, flush_pipline, invalidate_all;
   int   total = 0;
   int   bad   = 0;

   icache_lines_if #(.ADDR_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count, miss_count;
`endif

   icache_lines #(
      .ADDR_WIDTH      (32),
      .INDEX_BITS      (6),
      .LINE_WORDS_LOG2 (2)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .flush_pipline  (flush_pipline),
      .invalidate_all (invalidate_all),
      .bus            (bus)
`ifdef ICACHE_PERF_COUNTERS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One-cycle lookup; returns at the negedge after the lookup edge.
   task automatic start_read(input logic [31:0] a);
      bus.read_addr  = a;
      bus.is_reading = 1'b1;
      @(negedge clk_in);
      bus.is_reading = 1'b0;
   endtask

   // Memory model: answers nwords requests, word w gets data dbase+w.
   task automatic do_refill(input int first_w, input int nwords, input logic [31:0] dbase,
                            output logic [3:0][31:0] addrs, output int nseen);
      int t;
      addrs = '0;
      nseen = 0;
      for (int w = first_w; w < first_w + nwords; w++) begin
         t = 0;
         while (!bus.request_ins_from_memory_adaptor && t < 20) begin
            @(negedge clk_in);
            t++;
         end
         if (!bus.request_ins_from_memory_adaptor) return;
         addrs[w] = bus.insaddr_to_be_fetched_from_memory_adaptor;
         nseen++;
         @(negedge clk_in);
         bus.insfetch_task_done              = 1'b1;
         bus.ins_fetched_from_memory_adaptor = dbase + w;
         @(negedge clk_in);
         bus.insfetch_task_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; invalidate_all = 1'b0;
      bus.read_addr = '0; bus.is_reading = 1'b0;
      bus.ins_fetched_from_memory_adaptor = '0; bus.insfetch_task_done = 1'b0;
      repeat (2) @(negedge clk_in);
      total++; if (bus.is_ready !== 1'b1) begin bad++;
         $display("FAIL reset_ready got=%b want=1", bus.is_ready); end
      total++; if (bus.read_data !== 32'h0) begin bad++;
         $display("FAIL reset_data got=%h want=0", bus.read_data); end
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0) begin bad++;
         $display("FAIL reset_request got=%b want=0", bus.request_ins_from_memory_adaptor); end
      total++; if (bus.insaddr_to_be_fetched_from_memory_adaptor !== 32'h0) begin bad++;
         $display("FAIL reset_req_addr got=%h want=0",
                  bus.insaddr_to_be_fetched_from_memory_adaptor); end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_fill_and_hit();
      logic [3:0][31:0] addrs;
      int n;
      start_read(32'h0);
      total++; if (bus.is_ready !== 1'b0) begin bad++;
         $display("FAIL fill_miss_ready got=%b want=0", bus.is_ready); end
      do_refill(0, 4, 32'hA0, addrs, n);
      total++; if (n !== 4) begin bad++; $display("FAIL fill_nreq got=%0d want=4", n); end
      for (int i = 0; i < 4; i++) begin
         total++; if (addrs[i] !== 32'(i * 4)) begin bad++;
            $display("FAIL fill_addr%0d got=%h want=%h", i, addrs[i], i * 4); end
      end
      total++; if (bus.is_ready !== 1'b1 || bus.read_data !== 32'hA0) begin bad++;
         $display("FAIL fill_resp got=%b/%h want=1/a0", bus.is_ready, bus.read_data); end
      start_read(32'h8);
      total++; if (bus.is_ready !== 1'b1 || bus.read_data !== 32'hA2) begin bad++;
         $display("FAIL hit_resp got=%b/%h want=1/a2", bus.is_ready, bus.read_data); end
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0) begin bad++;
         $display("FAIL hit_no_req got=1 want=0"); end
      @(negedge clk_in);
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0) begin bad++;
         $display("FAIL hit_no_req_later got=1 want=0"); end
   endtask

   task automatic test_back_to_back();
      bus.read_addr = 32'h0; bus.is_reading = 1'b1;
      @(negedge clk_in);
      total++; if (bus.read_data !== 32'hA0) begin bad++;
         $display("FAIL b2b_0 got=%h want=a0", bus.read_data); end
      bus.read_addr = 32'hC;
      @(negedge clk_in);
      total++; if (bus.read_data !== 32'hA3) begin bad++;
         $display("FAIL b2b_1 got=%h want=a3", bus.read_data); end
      bus.read_addr = 32'h4;
      @(negedge clk_in);
      total++; if (bus.read_data !== 32'hA1 || bus.is_ready !== 1'b1) begin bad++;
         $display("FAIL b2b_2 got=%b/%h want=1/a1", bus.is_ready, bus.read_data); end
      bus.is_reading = 1'b0;
   endtask

   task automatic test_conflict();
      logic [3:0][31:0] addrs;
      int n;
      start_read(32'h404);
      total++; if (bus.is_ready !== 1'b0) begin bad++;
         $display("FAIL conf_miss got=%b want=0", bus.is_ready); end
      do_refill(0, 4, 32'hB0, addrs, n);
      total++; if (n !== 4 || addrs[0] !== 32'h400 || addrs[3] !== 32'h40C) begin bad++;
         $display("FAIL conf_addrs got=%0d/%h/%h want=4/400/40c", n, addrs[0], addrs[3]); end
      total++; if (bus.read_data !== 32'hB1) begin bad++;
         $display("FAIL conf_resp got=%h want=b1", bus.read_data); end
      start_read(32'h0);
      total++; if (bus.is_ready !== 1'b0 || bus.request_ins_from_memory_adaptor !== 1'b1)
      begin bad++;
         $display("FAIL conf_remiss got=%b/%b want=0/1", bus.is_ready,
                  bus.request_ins_from_memory_adaptor); end
      do_refill(0, 4, 32'hA0, addrs, n);
      total++; if (bus.read_data !== 32'hA0) begin bad++;
         $display("FAIL conf_refill got=%h want=a0", bus.read_data); end
   endtask

   task automatic test_flush();
      logic [3:0][31:0] addrs;
      int n;
      start_read(32'h20);
      do_refill(0, 2, 32'hC0, addrs, n);
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b1) begin bad++;
         $display("FAIL flush_midfill got=0 want=1"); end
      flush_pipline = 1'b1;
      @(negedge clk_in);
      flush_pipline = 1'b0;
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0 || bus.is_ready !== 1'b1)
      begin bad++;
         $display("FAIL flush_idle got=%b/%b want=0/1", bus.request_ins_from_memory_adaptor,
                  bus.is_ready); end
      total++; if (bus.read_data !== 32'hA0) begin bad++;
         $display("FAIL flush_data got=%h want=a0", bus.read_data); end
      bus.insfetch_task_done = 1'b1; bus.ins_fetched_from_memory_adaptor = 32'hDEAD;
      @(negedge clk_in);
      bus.insfetch_task_done = 1'b0;
      @(negedge clk_in);
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0 || bus.is_ready !== 1'b1 ||
                   bus.read_data !== 32'hA0) begin bad++;
         $display("FAIL flush_late_done got=%b/%b/%h want=0/1/a0",
                  bus.request_ins_from_memory_adaptor, bus.is_ready, bus.read_data); end
      start_read(32'h20);
      total++; if (bus.is_ready !== 1'b0) begin bad++;
         $display("FAIL flush_reread got=%b want=0", bus.is_ready); end
      do_refill(0, 4, 32'hC0, addrs, n);
      total++; if (n !== 4 || addrs[0] !== 32'h20 || addrs[3] !== 32'h2C) begin bad++;
         $display("FAIL flush_refill got=%0d/%h/%h want=4/20/2c", n, addrs[0], addrs[3]); end
      total++; if (bus.read_data !== 32'hC0) begin bad++;
         $display("FAIL flush_resp got=%h want=c0", bus.read_data); end
   endtask

   task automatic test_invalidate();
      logic [3:0][31:0] addrs;
      int n;
      start_read(32'h4);
      total++; if (bus.is_ready !== 1'b1 || bus.read_data !== 32'hA1) begin bad++;
         $display("FAIL inv_prehit got=%b/%h want=1/a1", bus.is_ready, bus.read_data); end
      invalidate_all = 1'b1;
      @(negedge clk_in);
      invalidate_all = 1'b0;
      start_read(32'h4);
      total++; if (bus.is_ready !== 1'b0) begin bad++;
         $display("FAIL inv_miss got=%b want=0", bus.is_ready); end
      do_refill(0, 4, 32'hD0, addrs, n);
      total++; if (n !== 4 || addrs[0] !== 32'h0) begin bad++;
         $display("FAIL inv_refill got=%0d/%h want=4/0", n, addrs[0]); end
      total++; if (bus.read_data !== 32'hD1) begin bad++;
         $display("FAIL inv_resp got=%h want=d1", bus.read_data); end
   endtask

   task automatic test_rdy_pause();
      logic [3:0][31:0] addrs;
      int n;
      int t;
      start_read(32'h30);
      t = 0;
      while (!bus.request_ins_from_memory_adaptor && t < 20) begin
         @(negedge clk_in);
         t++;
      end
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b1 ||
                   bus.insaddr_to_be_fetched_from_memory_adaptor !== 32'h30) begin bad++;
         $display("FAIL pause_req got=%b/%h want=1/30", bus.request_ins_from_memory_adaptor,
                  bus.insaddr_to_be_fetched_from_memory_adaptor); end
      @(negedge clk_in);
      rdy_in = 1'b0;
      bus.insfetch_task_done = 1'b1; bus.ins_fetched_from_memory_adaptor = 32'hE0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         total++; if (bus.is_ready !== 1'b0 || bus.request_ins_from_memory_adaptor !== 1'b0 ||
                      bus.insaddr_to_be_fetched_from_memory_adaptor !== 32'h30) begin bad++;
            $display("FAIL pause_hold%0d got=%b/%b/%h want=0/0/30", i, bus.is_ready,
                     bus.request_ins_from_memory_adaptor,
                     bus.insaddr_to_be_fetched_from_memory_adaptor); end
      end
      rdy_in = 1'b1;
      bus.insfetch_task_done = 1'b0;
      @(negedge clk_in);
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b0) begin bad++;
         $display("FAIL pause_no_progress got=1 want=0"); end
      bus.insfetch_task_done = 1'b1; bus.ins_fetched_from_memory_adaptor = 32'hE0;
      @(negedge clk_in);
      bus.insfetch_task_done = 1'b0;
      total++; if (bus.request_ins_from_memory_adaptor !== 1'b1 ||
                   bus.insaddr_to_be_fetched_from_memory_adaptor !== 32'h34) begin bad++;
         $display("FAIL pause_resume got=%b/%h want=1/34", bus.request_ins_from_memory_adaptor,
                  bus.insaddr_to_be_fetched_from_memory_adaptor); end
      do_refill(1, 3, 32'hE0, addrs, n);
      total++; if (n !== 3 || bus.is_ready !== 1'b1 || bus.read_data !== 32'hE0) begin bad++;
         $display("FAIL pause_done got=%0d/%b/%h want=3/1/e0", n, bus.is_ready,
                  bus.read_data); end
   endtask

`ifdef ICACHE_PERF_COUNTERS_EN
   task automatic test_perf();
      logic [3:0][31:0] addrs;
      int n;
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++;
         $display("FAIL perf_reset got=%0d/%0d want=0/0", hit_count, miss_count); end
      start_read(32'h0);
      do_refill(0, 4, 32'hA0, addrs, n);
      start_read(32'h0);
      start_read(32'h4);
      start_read(32'h8);
      total++; if (miss_count !== 32'd1) begin bad++;
         $display("FAIL perf_miss got=%0d want=1", miss_count); end
      total++; if (hit_count !== 32'd3) begin bad++;
         $display("FAIL perf_hit got=%0d want=3", hit_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_and_hit();
      test_back_to_back();
      test_conflict();
      test_flush();
      test_invalidate();
      test_rdy_pause();
`ifdef ICACHE_PERF_COUNTERS_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
